// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, decode-side control and the presented word.
// The master side is the fetch unit; the slave side is memory plus decode.
interface instruction_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall_i;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;
  logic        misalign_o;

  modport master (
    output imem_addr, if_valid, if_pc, if_instr, if_fault, misalign_o,
    input  imem_instr, stall_i, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, if_valid, if_pc, if_instr, if_fault, misalign_o,
    output imem_instr, stall_i, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch-stage requester: owns the PC, tags 1-cycle-latency memory words with their PC,
// parks one word across decode stalls and squashes in-flight words on redirect.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 64,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       resetn,
  instruction_fetch_unit_if.master   bus
);

  localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES) - 32'd4;

  logic [31:0] r_pc;
  logic        r_infl_v;
  logic [31:0] r_infl_pc;
  logic        r_infl_flt;
  logic        r_hold_v;
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_instr;
  logic        r_hold_flt;
  logic        r_misalign;

  logic [31:0] w_issue_addr;
  logic        w_issue;
  logic [31:0] w_infl_instr;
  logic [31:0] w_pres_pc;
  logic [31:0] w_pres_instr;
  logic        w_pres_flt;
  logic        w_if_valid;

  // Redirect wins over everything; otherwise issue when decode accepts or the pipe is empty.
  assign w_issue_addr = bus.redirect_valid ? {bus.redirect_pc[31:2], 2'b00} : r_pc;
  assign w_issue      = bus.redirect_valid | ~bus.stall_i | (~r_hold_v & ~r_infl_v);

  assign w_infl_instr = r_infl_flt ? NOP_INSTR : bus.imem_instr;
  assign w_pres_pc    = r_hold_v ? r_hold_pc    : r_infl_pc;
  assign w_pres_instr = r_hold_v ? r_hold_instr : w_infl_instr;
  assign w_pres_flt   = r_hold_v ? r_hold_flt   : r_infl_flt;
  assign w_if_valid   = (r_hold_v | r_infl_v) & ~bus.redirect_valid;

  assign bus.imem_addr  = w_issue_addr;
  assign bus.if_valid   = w_if_valid;
  assign bus.if_pc      = w_if_valid ? w_pres_pc    : 32'd0;
  assign bus.if_instr   = w_if_valid ? w_pres_instr : 32'd0;
  assign bus.if_fault   = w_if_valid & w_pres_flt;
  assign bus.misalign_o = r_misalign;

  // NOTE: only the valid bits and PC are reset; the payload registers are qualified by them.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pc       <= RESET_PC;
      r_infl_v   <= 1'b0;
      r_hold_v   <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
      if (w_issue) begin
        r_infl_v   <= 1'b1;
        r_infl_pc  <= w_issue_addr;
        r_infl_flt <= (w_issue_addr > LAST_WORD);
        r_pc       <= w_issue_addr + 32'd4;
        r_hold_v   <= 1'b0;
      end else if (r_infl_v) begin
        // Stalled with a word arriving: park it; hold and in-flight are never both valid.
        r_hold_v     <= 1'b1;
        r_hold_pc    <= r_infl_pc;
        r_hold_instr <= w_infl_instr;
        r_hold_flt   <= r_infl_flt;
        r_infl_v     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: big-endian memory model, per-cycle
// expected outputs queued at drive time and compared at the falling edge.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    logic [31:0] addr;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  logic [7:0] mem [0:63];
  exp_t sb_q[$];

  int n_vec  = 0;
  int n_miss = 0;

  // Reference state, written from the issue rules
  logic [31:0] m_pc;
  logic        m_iv, m_if, m_hv, m_hf, m_mis;
  logic [31:0] m_ipc, m_hpc, m_hins;

  // Last sampled DUT outputs, for directed checks
  logic        s_valid, s_fault, s_mis;
  logic [31:0] s_pc, s_instr, s_addr;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .IMEM_BYTES(64),
    .NOP_INSTR (NOP)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0] b;
    b = a[5:0];
    if (a <= 32'd60) return {mem[b], mem[b + 6'd1], mem[b + 6'd2], mem[b + 6'd3]};
    return OOR_DATA;
  endfunction

  always @(posedge clk) bus.imem_instr <= resetn ? mem_word(bus.imem_addr) : 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_iv = 0; m_hv = 0; m_mis = 0;
    m_if = 0; m_ipc = 0; m_hpc = 0; m_hins = 0; m_hf = 0;
  endtask

  // One clock: drive, predict, sample at negedge, advance the reference at posedge.
  task automatic step(input logic rst_v, input logic stall, input logic rv, input logic [31:0] rpc);
    exp_t e, got;
    logic [31:0] iins, ia;
    logic        issue;
    resetn = rst_v; bus.stall_i = stall; bus.redirect_valid = rv; bus.redirect_pc = rpc;

    iins    = m_if ? NOP : mem_word(m_ipc);
    ia      = rv ? {rpc[31:2], 2'b00} : m_pc;
    e.valid = (m_hv | m_iv) & ~rv;
    e.pc    = e.valid ? (m_hv ? m_hpc : m_ipc) : 32'd0;
    e.instr = e.valid ? (m_hv ? m_hins : iins) : 32'd0;
    e.fault = e.valid & (m_hv ? m_hf : m_if);
    e.addr  = ia;
    e.mis   = m_mis;
    sb_q.push_back(e);

    @(negedge clk);
    s_valid = bus.if_valid; s_pc = bus.if_pc; s_instr = bus.if_instr;
    s_fault = bus.if_fault; s_addr = bus.imem_addr; s_mis = bus.misalign_o;
    got = sb_q.pop_front();
    check("if_valid",   {31'd0, s_valid}, {31'd0, got.valid});
    check("if_pc",      s_pc,             got.pc);
    check("if_instr",   s_instr,          got.instr);
    check("if_fault",   {31'd0, s_fault}, {31'd0, got.fault});
    check("imem_addr",  s_addr,           got.addr);
    check("misalign_o", {31'd0, s_mis},   {31'd0, got.mis});

    @(posedge clk);
    if (!rst_v) model_reset();
    else begin
      issue = rv | ~stall | (~m_hv & ~m_iv);
      m_mis = rv & (rpc[1:0] != 2'b00);
      if (issue) begin
        m_iv = 1; m_ipc = ia; m_if = (ia > 32'd60); m_pc = ia + 32'd4; m_hv = 0;
      end else if (m_iv) begin
        m_hv = 1; m_hpc = m_ipc; m_hins = iins; m_hf = m_if; m_iv = 0;
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 37 + 5);
    {mem[4], mem[5], mem[6], mem[7]}     = 32'h00F0_0093;
    {mem[20], mem[21], mem[22], mem[23]} = 32'h00C0_9183;

    resetn = 0; bus.stall_i = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    step(0, 0, 0, 0);
    check("rst_valid", {31'd0, s_valid}, 32'd0);

    // T1: sequential fetch
    step(1, 0, 0, 0);
    check("t1_addr0", s_addr, 32'h0);
    check("t1_bubble", {31'd0, s_valid}, 32'd0);
    step(1, 0, 0, 0);
    check("t1_addr4", s_addr, 32'h4);
    step(1, 0, 0, 0);
    check("t1_pc", s_pc, 32'h4);
    check("t1_instr", s_instr, 32'h00F0_0093);

    // T2: three stall cycles while pc 8 is presented
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      check("t2_hold_pc", s_pc, 32'h8);
      check("t2_addr", s_addr, 32'hC);
    end
    step(1, 0, 0, 0);
    check("t2_release_pc", s_pc, 32'h8);
    step(1, 0, 0, 0);
    check("t2_next_pc", s_pc, 32'hC);

    // T3: redirect overrides stall
    step(1, 1, 1, 32'h14);
    check("t3_squash", {31'd0, s_valid}, 32'd0);
    step(1, 1, 0, 0);
    check("t3_pc", s_pc, 32'h14);
    check("t3_instr", s_instr, 32'h00C0_9183);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // T4: misaligned redirect target
    step(1, 0, 1, 32'h16);
    check("t4_addr", s_addr, 32'h14);
    step(1, 0, 0, 0);
    check("t4_mis_hi", {31'd0, s_mis}, 32'd1);
    check("t4_pc", s_pc, 32'h14);
    step(1, 0, 0, 0);
    check("t4_mis_lo", {31'd0, s_mis}, 32'd0);

    // T5: run off the end of memory, then wrap the PC
    step(1, 0, 1, 32'h38);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("t5_pc3c", s_pc, 32'h3C);
    check("t5_flt3c", {31'd0, s_fault}, 32'd0);
    step(1, 0, 0, 0);
    check("t5_pc40", s_pc, 32'h40);
    check("t5_flt40", {31'd0, s_fault}, 32'd1);
    check("t5_nop", s_instr, NOP);
    step(1, 0, 1, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    check("wrap_addr", s_addr, 32'h0);
    step(1, 0, 0, 0);
    check("wrap_pc", s_pc, 32'h0);

    // T6: reset while a word is parked
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("t6_invalid", {31'd0, s_valid}, 32'd0);
    step(1, 1, 0, 0);
    check("t6_pc", s_pc, RESET_PC);

    // Random traffic, mostly in range with occasional redirects
    for (int i = 0; i < 300; i++) begin
      logic st, rv;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 2) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      tgt = 32'($urandom_range(0, 70));
      step(($urandom_range(0, 99) != 0), st, rv, tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
